// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The bit counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow out bo.
// Latency: combinational. Backpressure: none, pure logic.
// Handshake: none; the cell is driven directly by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin, LSB first). Optional signed overflow output under SERIAL_SUB_OVF_EN.
// Latency: result valid WIDTH cycles after operand accept.
// Backpressure: DONE holds the result until out_ready; in_ready only while IDLE.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH:0]   diff_ext;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_r;
    logic             d;
    logic             bo;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_r;
`endif

    full_subtractor u_fs (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (state == SHIFT) && (cnt == LAST);
    // New bit enters at the MSB; the slice form also works when WIDTH is 1.
    assign diff_ext = {d, diff_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)                   state_nxt = SHIFT;
            SHIFT:   if (last_bit)                 state_nxt = DONE;
            DONE:    if (out_valid && out_ready)   state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            cnt    <= '0;
            diff_r <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            diff_r <= diff_ext[WIDTH:1];
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            br     <= bo;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                bout_r <= bo;
`ifdef SERIAL_SUB_OVF_EN
                // d here is the final result MSB, borrow chain already folded in.
                ovf_r  <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
            end
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor: computes A − B − bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract counterpart to the team's full adder. It is used where area matters more than latency, and takes operands and returns results through valid/ready handshakes.

## Interface
- WIDTH, 8: operand and result width in bits; legal values are 1 and above.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  out  1  borrow out; 1 when a < b + bin (unsigned).
- ovf  out  1  signed overflow. Present only under SERIAL_SUB_OVF_EN.

## Operation
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - SHIFT: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- IDLE → SHIFT on the edge where in_valid && in_ready.
  - Capture a and b into shift registers, bin into the borrow register.
  - Clear the bit counter and the diff register.
- SHIFT, every cycle:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift diff right, inserting d at the MSB.
  - Shift the a and b registers right.
  - Increment the counter.
- SHIFT → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1).
  - bout takes the final br.
- DONE → IDLE on the edge where out_valid && out_ready.
- While out_valid is high, diff, bout and ovf are stable.
- in_valid is ignored outside IDLE. No operand is queued.
- out_ready is ignored outside DONE.
- WIDTH = 1: SHIFT lasts exactly one cycle.
- Result arithmetic is unsigned modulo 2^WIDTH.
- bout is the true unsigned borrow.

## Timing
- Reset (async assert, sync deassert by the system):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - diff = 0, bout = 0, ovf = 0.
  - Counter = 0, borrow register = 0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No result is emitted.
- Latency:
  - Operands are accepted on edge E.
  - out_valid rises after edge E + WIDTH.
  - The result is therefore visible WIDTH cycles after acceptance.
- Throughput: at best one operation per WIDTH + 2 cycles. This is one DONE cycle plus one IDLE cycle.
- The next accept can occur at the earliest on the edge after the output handshake edge.
- Backpressure: DONE holds indefinitely while out_ready = 0.
- in_ready is a pure function of state. It does not depend combinationally on in_valid.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists.
  - MSBs of a and b are captured at accept.
  - ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), with the result MSB including the bin contribution.
  - ovf is registered with diff on entry to DONE.
  - ovf resets to 0.
- SERIAL_SUB_OVF_EN undefined:
  - No ovf port.
  - No MSB capture registers.
  - All other behaviour is identical.

## Structure
- Package serial_sub_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Counter width function: $clog2 of WIDTH, minimum 1.
- Sub-module full_subtractor: combinational cell.
  - Ports: a, b, bi → d, bo.
  - Instantiated once; it is the per-bit datapath.

## Test plan
- WIDTH = 8, a = 0x05, b = 0x03, bin = 0 → diff = 0x02, bout = 0. out_valid rises 8 cycles after accept.
- a = 0x03, b = 0x05, bin = 0 → diff = 0xFE, bout = 1.
- a = 0x00, b = 0x00, bin = 1 → diff = 0xFF, bout = 1.
- Hold out_ready = 0 for 5 cycles in DONE → diff, bout and out_valid stay stable. Next accept occurs no earlier than the edge after the handshake.
- Pulse in_valid with a = 0xAA during SHIFT → ignored. The result still reflects the original operands.
- Assert rst_n low at SHIFT bit 3 → all outputs read their reset values and in_ready = 1. The next operation, 0x10 − 0x01, gives 0x0F.
- Under SERIAL_SUB_OVF_EN: 0x80 − 0x01 → diff = 0x7F, ovf = 1. 0x7F − 0x01 → ovf = 0.
